// File: rtl/chan_arb_pkg.sv
// Types shared by the channel arbiter and its round-robin picker.
package pkg;

    typedef logic [1:0] my_type_t;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } chan_arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chan_arb_rr_pick.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module chan_arb_rr_pick
    import pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int PW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PW-1:0]    ptr,
    output logic             any,
    output logic [PW-1:0]    index
);

    logic [PW-1:0] cand;

    // Scan from the far end so the candidate closest to ptr is written last.
    always_comb begin
        any   = 1'b0;
        index = '0;
        cand  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr) + k) % N_REQ);
            if (valid[cand]) begin
                any   = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/chan_arb.sv
// N-way burst arbiter feeding a single registered output slot.
//
//   state | meaning
//   IDLE  | no owner; round-robin pick from ptr on every free slot
//   OWN   | owner locked until BURST_MAX beats or owner goes idle
module chan_arb
    import pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int BURST_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  my_type_t [N_REQ-1:0]     req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_valid,
    output my_type_t                 out_data,
    output logic [$clog2(N_REQ)-1:0] out_src,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(BURST_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX);
    localparam logic [PW-1:0] IDX_LAST = PW'(N_REQ - 1);

    chan_arb_state_t state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   cnt_inc;

    logic            out_valid_q;
    my_type_t        out_data_q;
    logic [PW-1:0]   out_src_q;

    logic            slot_free;
    logic            pick_any;
    logic [PW-1:0]   pick_idx;
    logic            grant;
    logic [PW-1:0]   grant_idx;

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
        return (i == IDX_LAST) ? '0 : i + PW'(1);
    endfunction

    chan_arb_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr_q),
        .any   (pick_any),
        .index (pick_idx)
    );

    assign slot_free = !out_valid_q || out_ready;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        grant     = 1'b0;
        grant_idx = owner_q;
        cnt_inc   = cnt_q + CW'(1);
        case (state_q)
            IDLE: begin
                if (slot_free && pick_any) begin
                    grant     = 1'b1;
                    grant_idx = pick_idx;
                    owner_d   = pick_idx;
                    cnt_d     = CW'(1);
                    // A one-beat burst never locks; rotate straight past the winner.
                    if (BURST_MAX == 1) begin
                        ptr_d = next_idx(pick_idx);
                    end else begin
                        state_d = OWN;
                    end
                end
            end
            OWN: begin
                if (slot_free) begin
                    if (req_valid[owner_q]) begin
                        grant = 1'b1;
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_LAST) begin
                            state_d = IDLE;
                            ptr_d   = next_idx(owner_q);
                        end
                    end else begin
                        state_d = IDLE;
                        ptr_d   = next_idx(owner_q);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (grant && rst_n) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            if (grant) begin
                out_valid_q <= 1'b1;
                out_data_q  <= req_data[grant_idx];
                out_src_q   <= grant_idx;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;
    assign busy      = rst_n && (state_q == OWN);

    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
    a_cnt_bound:    assert property (@(posedge clk) disable iff (!rst_n) cnt_q <= CNT_LAST);

endmodule

// File: tb/tb_chan_arb.sv
// Directed-vector and scoreboard bench for chan_arb (N_REQ=2 with BURST_MAX 4 and 1).
module tb_chan_arb;
    import pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           a_rst_n, a_ordy, a_ov, a_os, a_busy;
    logic [1:0]     a_valid, a_ready;
    my_type_t [1:0] a_data;
    my_type_t       a_od;

    logic           b_rst_n, b_ordy, b_ov, b_os, b_busy;
    logic [1:0]     b_valid, b_ready;
    my_type_t [1:0] b_data;
    my_type_t       b_od;

    chan_arb #(.N_REQ(2), .BURST_MAX(4)) dut (
        .clk(clk), .rst_n(a_rst_n), .req_valid(a_valid), .req_data(a_data),
        .req_ready(a_ready), .out_valid(a_ov), .out_data(a_od), .out_src(a_os),
        .out_ready(a_ordy), .busy(a_busy)
    );

    chan_arb #(.N_REQ(2), .BURST_MAX(1)) dut_b1 (
        .clk(clk), .rst_n(b_rst_n), .req_valid(b_valid), .req_data(b_data),
        .req_ready(b_ready), .out_valid(b_ov), .out_data(b_od), .out_src(b_os),
        .out_ready(b_ordy), .busy(b_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic [1:0] valid;
        logic       ordy;
        logic [1:0] e_ready;
        logic       e_ov;
        logic [1:0] e_od;
        logic       e_os;
        logic       e_busy;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [1:0] v, input logic o,
                                input logic [1:0] er, input logic eov, input logic [1:0] eod,
                                input logic eos, input logic eb);
        vec_t t;
        t.rst_n = r; t.valid = v; t.ordy = o;
        t.e_ready = er; t.e_ov = eov; t.e_od = eod; t.e_os = eos; t.e_busy = eb;
        return t;
    endfunction

    vec_t vecs[21];

    logic [1:0] seq[2];
    int         q_src[$];
    int         q_dat[$];
    logic       held;
    my_type_t   hd;
    logic       hs;
    int         es, ed;

    initial begin
        // rst, valid, out_ready | req_ready, out_valid, out_data, out_src, busy
        vecs[0]  = mk(0, 2'b11, 1, 2'b00, 0, 2'b00, 0, 0);
        vecs[1]  = mk(1, 2'b11, 1, 2'b01, 1, 2'b01, 0, 1);
        vecs[2]  = mk(1, 2'b11, 1, 2'b01, 1, 2'b01, 0, 1);
        vecs[3]  = mk(1, 2'b11, 1, 2'b01, 1, 2'b01, 0, 1);
        vecs[4]  = mk(1, 2'b11, 1, 2'b01, 1, 2'b01, 0, 0);
        vecs[5]  = mk(1, 2'b11, 1, 2'b10, 1, 2'b10, 1, 1);
        vecs[6]  = mk(1, 2'b11, 1, 2'b10, 1, 2'b10, 1, 1);
        vecs[7]  = mk(1, 2'b11, 1, 2'b10, 1, 2'b10, 1, 1);
        vecs[8]  = mk(1, 2'b11, 1, 2'b10, 1, 2'b10, 1, 0);
        vecs[9]  = mk(1, 2'b11, 1, 2'b01, 1, 2'b01, 0, 1);
        vecs[10] = mk(1, 2'b11, 0, 2'b00, 1, 2'b01, 0, 1);
        vecs[11] = mk(1, 2'b11, 0, 2'b00, 1, 2'b01, 0, 1);
        vecs[12] = mk(1, 2'b11, 0, 2'b00, 1, 2'b01, 0, 1);
        vecs[13] = mk(1, 2'b11, 1, 2'b01, 1, 2'b01, 0, 1);
        vecs[14] = mk(1, 2'b10, 1, 2'b00, 0, 2'b01, 0, 0);
        vecs[15] = mk(1, 2'b11, 1, 2'b10, 1, 2'b10, 1, 1);
        vecs[16] = mk(1, 2'b11, 1, 2'b10, 1, 2'b10, 1, 1);
        vecs[17] = mk(0, 2'b11, 1, 2'b00, 0, 2'b00, 0, 0);
        vecs[18] = mk(1, 2'b11, 1, 2'b01, 1, 2'b01, 0, 1);
        vecs[19] = mk(0, 2'b00, 1, 2'b00, 0, 2'b00, 0, 0);
        vecs[20] = mk(1, 2'b10, 1, 2'b10, 1, 2'b10, 1, 1);

        a_data[0] = 2'b01;
        a_data[1] = 2'b10;
        b_rst_n = 1'b0;
        b_valid = 2'b00;
        b_ordy  = 1'b1;
        b_data[0] = 2'b01;
        b_data[1] = 2'b10;

        for (int i = 0; i < 21; i++) begin
            a_rst_n = vecs[i].rst_n;
            a_valid = vecs[i].valid;
            a_ordy  = vecs[i].ordy;
            #1;
            chk($sformatf("v%0d req_ready", i), 8'(a_ready), 8'(vecs[i].e_ready));
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", i), 8'(a_ov), 8'(vecs[i].e_ov));
            chk($sformatf("v%0d out_data", i), 8'(a_od), 8'(vecs[i].e_od));
            chk($sformatf("v%0d out_src", i), 8'(a_os), 8'(vecs[i].e_os));
            chk($sformatf("v%0d busy", i), 8'(a_busy), 8'(vecs[i].e_busy));
        end

        // BURST_MAX=1: strict alternation, never locked.
        b_rst_n = 1'b1;
        b_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("b1 k%0d req_ready", k), 8'(b_ready), (k % 2 == 0) ? 8'h01 : 8'h02);
            @(posedge clk); #1;
            chk($sformatf("b1 k%0d out_src", k), 8'(b_os), 8'(k % 2));
            chk($sformatf("b1 k%0d out_valid", k), 8'(b_ov), 8'h01);
            chk($sformatf("b1 k%0d busy", k), 8'(b_busy), 8'h00);
        end

        // Random valid/backpressure with a per-requester sequence scoreboard.
        a_rst_n = 1'b0;
        a_valid = 2'b00;
        a_ordy  = 1'b1;
        @(posedge clk); #1;
        a_rst_n = 1'b1;
        seq[0] = 2'd0;
        seq[1] = 2'd0;
        for (int c = 0; c < 400; c++) begin
            a_valid   = 2'($urandom_range(0, 3));
            a_ordy    = ($urandom_range(0, 3) != 0);
            a_data[0] = seq[0];
            a_data[1] = seq[1];
            #1;
            chk("sb ready_onehot", 8'($countones(a_ready) <= 1), 8'h01);
            if (a_ov && !a_ordy) chk("sb ready_when_full", 8'(a_ready), 8'h00);
            if (a_ov && a_ordy) begin
                if (q_src.size() == 0) begin
                    chk("sb phantom_beat", 8'(q_src.size()), 8'h01);
                end else begin
                    es = q_src.pop_front();
                    ed = q_dat.pop_front();
                    chk("sb beat_src", 8'(a_os), 8'(es));
                    chk("sb beat_data", 8'(a_od), 8'(ed));
                end
            end
            held = a_ov && !a_ordy;
            hd   = a_od;
            hs   = a_os;
            for (int r = 0; r < 2; r++) begin
                if (a_valid[r] && a_ready[r]) begin
                    q_src.push_back(r);
                    q_dat.push_back(int'(seq[r]));
                    seq[r] = seq[r] + 2'd1;
                end
            end
            @(posedge clk); #1;
            chk("sb out_valid_vs_pending", 8'(a_ov), 8'(q_src.size() != 0));
            if (held) begin
                chk("sb stall_data", 8'(a_od), 8'(hd));
                chk("sb stall_src", 8'(a_os), 8'(hs));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
